// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment pair reader.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
// Glyph patterns are active low and ordered {a,b,c,d,e,f,g}, with bit 6 holding segment a.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int VAL_W = 4;

  localparam logic [SEG_W-1:0] SEG_0        = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1        = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2        = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3        = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4        = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5        = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6        = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7        = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8        = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9        = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_BLANK    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_TENS_ONE = 7'b1001111;

  typedef enum logic {S_IDLE, S_SETTLE} state_t;

  // Result of decoding a single digit position.
  typedef struct packed {
    logic             legal;
    logic [VAL_W-1:0] digit;
  } glyph_t;

  // Result of decoding the tens/ones pair.
  typedef struct packed {
    logic             legal;
    logic [VAL_W-1:0] value;
  } pair_t;

  // A lit tens "1" only pairs with ones digits 0..5, so that the value fits in 4 bits.
  // Illegal pairs report value 0.
  function automatic pair_t pair_decode(glyph_t hi, glyph_t lo);
    pair_t r;
    r.legal = hi.legal && lo.legal && ((hi.digit == '0) || (lo.digit <= 4'd5));
    if (!r.legal)
      r.value = '0;
    else if (hi.digit != '0)
      r.value = 4'd10 + lo.digit;
    else
      r.value = lo.digit;
    return r;
  endfunction

endpackage

// File: rtl/seg7_pair_reader_if.sv
// Result channel from the segment reader to its consumer.
// Latency: n/a (wires only).
// Backpressure: the consumer drives out_ready. A beat transfers on an edge where out_valid && out_ready.
// Signals: out_valid/out_ready handshake, out_value[3:0], out_err, sticky overrun,
//   and err_count[7:0] when SEG7_ERR_CNT_EN is defined.
interface seg7_pair_reader_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_value;
  logic       out_err;
  logic       overrun;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0] err_count;

  modport master (output out_valid, out_value, out_err, overrun, err_count, input out_ready);
  modport slave  (input out_valid, out_value, out_err, overrun, err_count, output out_ready);
`else
  modport master (output out_valid, out_value, out_err, overrun, input out_ready);
  modport slave  (input out_valid, out_value, out_err, overrun, output out_ready);
`endif
endinterface

// File: rtl/seg7_glyph_decode.sv
// Decodes one active-low 7-segment glyph into {legal, digit}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: glyph[6:0] in, dec (glyph_t) out.
// TENS=1 accepts only blank (0) and "1" (1). TENS=0 accepts the glyphs 0..9.
module seg7_glyph_decode
  import seg7_pkg::*;
#(
  parameter bit TENS = 1'b0
) (
  input  logic [SEG_W-1:0] glyph,
  output glyph_t           dec
);

  always_comb begin
    dec = '0;
    if (TENS) begin
      case (glyph)
        SEG_BLANK:    dec = '{legal: 1'b1, digit: 4'd0};
        SEG_TENS_ONE: dec = '{legal: 1'b1, digit: 4'd1};
        default:      dec = '0;
      endcase
    end else begin
      case (glyph)
        SEG_0:   dec = '{legal: 1'b1, digit: 4'd0};
        SEG_1:   dec = '{legal: 1'b1, digit: 4'd1};
        SEG_2:   dec = '{legal: 1'b1, digit: 4'd2};
        SEG_3:   dec = '{legal: 1'b1, digit: 4'd3};
        SEG_4:   dec = '{legal: 1'b1, digit: 4'd4};
        SEG_5:   dec = '{legal: 1'b1, digit: 4'd5};
        SEG_6:   dec = '{legal: 1'b1, digit: 4'd6};
        SEG_7:   dec = '{legal: 1'b1, digit: 4'd7};
        SEG_8:   dec = '{legal: 1'b1, digit: 4'd8};
        SEG_9:   dec = '{legal: 1'b1, digit: 4'd9};
        default: dec = '0;
      endcase
    end
  end

endmodule

// File: rtl/seg7_pair_reader.sv
// Reads back a dual 7-segment display, debounces it and delivers the decoded value 0..15 or an error flag.
// Latency: out_valid rises after edge N+STABLE_CYCLES+2 when the pattern is first sampled on edge N.
// Backpressure: one output slot. A result that settles while the slot is full is dropped and sets overrun.
// Ports: clk, rst_n (async, active low), seg_lo[6:0] / seg_hi[6:0] (active low), out_if (master).
// Optional: defining SEG7_ERR_CNT_EN adds out_if.err_count, a saturating count of error beats transferred.
module seg7_pair_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEG_W-1:0]    seg_lo,
  input  logic [SEG_W-1:0]    seg_hi,
  seg7_pair_reader_if.master  out_if
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2*SEG_W-1:0] sync1, sync2, snapshot, last_rep;
  logic               last_vld;   // last_rep holds a real pattern (cleared by reset)
  logic [CNT_W-1:0]   cnt;
  state_t             state;

  logic             out_valid_q, out_err_q, overrun_q;
  logic [VAL_W-1:0] out_value_q;

  glyph_t hi_dec, lo_dec;
  pair_t  pair;

  // Decode from the snapshot so that the result matches exactly the pattern that settled.
  seg7_glyph_decode #(.TENS(1'b1)) u_dec_hi (.glyph(snapshot[2*SEG_W-1:SEG_W]), .dec(hi_dec));
  seg7_glyph_decode #(.TENS(1'b0)) u_dec_lo (.glyph(snapshot[SEG_W-1:0]),       .dec(lo_dec));

  assign pair = pair_decode(hi_dec, lo_dec);

  logic settle_done, new_result, xfer, slot_free;
  assign settle_done = (state == S_SETTLE) && (cnt == CNT_MAX);
  // A pattern identical to the last one reported is suppressed. This keeps a steady display from streaming.
  assign new_result  = settle_done && !(last_vld && (snapshot == last_rep));
  assign xfer        = out_valid_q && out_if.out_ready;
  assign slot_free   = !out_valid_q || out_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '1;
      sync2       <= '1;
      snapshot    <= '1;
      last_rep    <= '1;
      last_vld    <= 1'b0;
      cnt         <= '0;
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1 <= {seg_hi, seg_lo};
      sync2 <= sync1;

      case (state)
        S_IDLE: begin
          if (sync2 != snapshot) begin
            snapshot <= sync2;
            cnt      <= CNT_ONE;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_MAX) begin
            state <= S_IDLE;
            if (new_result) begin
              last_rep <= snapshot;
              last_vld <= 1'b1;
            end
          end else if (sync2 == snapshot) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            snapshot <= sync2;
            cnt      <= CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // If a load and a transfer fall on the same edge, the load wins and the slot stays full.
      if (new_result && slot_free) begin
        out_valid_q <= 1'b1;
        out_value_q <= pair.value;
        out_err_q   <= !pair.legal;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end

      if (new_result && !slot_free)
        overrun_q <= 1'b1;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_value = out_value_q;
  assign out_if.out_err   = out_err_q;
  assign out_if.overrun   = overrun_q;

`ifdef SEG7_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (xfer && out_err_q && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign out_if.err_count = err_cnt_q;
`endif

endmodule
